// File: rtl/intr_src_pkg.sv
// Shared types and sizing helpers for the external-interrupt source controller.
package intr_src_pkg;

    localparam int DEF_NUM_SRC     = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// Multi-flop synchronizer for one asynchronous IRQ line plus a one-cycle history
// flop, giving the synchronized level and its rising-edge pulse.
module intr_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_async,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_async};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/intr_src_ctl.sv
// Source side of the external-interrupt handshake: capture, mask, prioritise and
// hold one request to the interrupt controller from acceptance until exception return.
import intr_src_pkg::*;

module intr_src_ctl #(
    parameter int  NUM_SRC     = DEF_NUM_SRC,
    parameter int  SYNC_STAGES = DEF_SYNC_STAGES,
    localparam int IDX_W       = idx_w(NUM_SRC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_async,
    input  logic [NUM_SRC-1:0] irq_edge_mode,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               intr_taken,
    input  logic               ertn_w,
    input  logic [NUM_SRC-1:0] overrun_clr,
    output logic               ext_intr_sync,
    output logic [IDX_W-1:0]   irq_id,
    output logic               irq_id_vld,
    output logic [NUM_SRC-1:0] irq_pending,
    output logic [NUM_SRC-1:0] irq_overrun
);

    logic [NUM_SRC-1:0] sync_vec;
    logic [NUM_SRC-1:0] rise_vec;
    logic [NUM_SRC-1:0] set_vec;
    logic [NUM_SRC-1:0] clr_vec;
    logic [NUM_SRC-1:0] ovr_set_vec;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] overrun_q, overrun_d;
    logic [IDX_W-1:0]   sel_id;
    logic [IDX_W-1:0]   irq_id_q;
    logic               ext_q;
    logic               vld_q;
    logic               accept;
    state_e             state_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            intr_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .clk       (clk),
                .reset     (reset),
                .irq_async (irq_async[gi]),
                .sync_o    (sync_vec[gi]),
                .rise_o    (rise_vec[gi])
            );

            assign clr_vec[gi] = accept && (sel_id == IDX_W'(gi));
        end
    endgenerate

    assign cand = pending_q & ~irq_mask;

    // Lowest index has highest priority.
    always_comb begin
        sel_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_id = IDX_W'(i);
            end
        end
    end

    // A withdrawn candidate set takes precedence over a same-cycle acceptance.
    assign accept = (state_q == REQ) && intr_taken && (|cand);

    assign set_vec     = (irq_edge_mode & rise_vec) | (~irq_edge_mode & sync_vec);
    assign ovr_set_vec = irq_edge_mode & rise_vec & pending_q & ~clr_vec;
    assign pending_d   = (pending_q & ~clr_vec) | set_vec;
    assign overrun_d   = (overrun_q & ~overrun_clr) | ovr_set_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            irq_id_q <= '0;
            ext_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|cand) begin
                        state_q  <= REQ;
                        irq_id_q <= sel_id;
                        ext_q    <= 1'b1;
                    end
                end
                REQ: begin
                    if (!(|cand)) begin
                        state_q <= IDLE;
                        ext_q   <= 1'b0;
                    end else begin
                        irq_id_q <= sel_id;
                        if (intr_taken) begin
                            state_q <= SERVICE;
                            vld_q   <= 1'b1;
                        end
                    end
                end
                SERVICE: begin
                    if (ertn_w) begin
                        state_q <= IDLE;
                        ext_q   <= 1'b0;
                        vld_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ext_q   <= 1'b0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ext_intr_sync = ext_q;
    assign irq_id        = irq_id_q;
    assign irq_id_vld    = vld_q;
    assign irq_pending   = pending_q;
    assign irq_overrun   = overrun_q;

endmodule

// File: tb/tb_intr_src_ctl.sv
// Cycle-table bench for intr_src_ctl: each row drives one cycle of inputs and
// pushes the outputs expected after that clock edge onto a scoreboard queue.
module tb_intr_src_ctl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_async;
    logic [7:0] irq_edge_mode;
    logic [7:0] irq_mask;
    logic       intr_taken;
    logic       ertn_w;
    logic [7:0] overrun_clr;
    logic       ext_intr_sync;
    logic [2:0] irq_id;
    logic       irq_id_vld;
    logic [7:0] irq_pending;
    logic [7:0] irq_overrun;

    intr_src_ctl #(
        .NUM_SRC     (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .irq_async     (irq_async),
        .irq_edge_mode (irq_edge_mode),
        .irq_mask      (irq_mask),
        .intr_taken    (intr_taken),
        .ertn_w        (ertn_w),
        .overrun_clr   (overrun_clr),
        .ext_intr_sync (ext_intr_sync),
        .irq_id        (irq_id),
        .irq_id_vld    (irq_id_vld),
        .irq_pending   (irq_pending),
        .irq_overrun   (irq_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] irq;
        logic [7:0] emode;
        logic [7:0] mask;
        logic [7:0] oclr;
        logic       tk;
        logic       er;
        logic       rst;
        logic       ext;
        logic [2:0] id;
        logic       vld;
        logic [7:0] pend;
        logic [7:0] ovr;
    } vec_t;

    typedef struct {
        int         cyc;
        int         idx;
        logic       ext;
        logic [2:0] id;
        logic       vld;
        logic [7:0] pend;
        logic [7:0] ovr;
    } exp_t;

    vec_t       vecs[$];
    exp_t       sb[$];
    exp_t       e;
    logic [7:0] cur_em;
    logic [7:0] cur_mask;
    int         cyc_cnt = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic st(input logic [7:0] irq, input logic tk, input logic er,
                      input logic [7:0] oclr, input logic rst,
                      input logic ext, input logic [2:0] id, input logic vld,
                      input logic [7:0] pend, input logic [7:0] ovr);
        vec_t v;
        v.irq = irq;  v.emode = cur_em; v.mask = cur_mask; v.oclr = oclr;
        v.tk = tk;    v.er = er;        v.rst = rst;
        v.ext = ext;  v.id = id;        v.vld = vld;  v.pend = pend; v.ovr = ovr;
        vecs.push_back(v);
    endtask

    task automatic quiet(input int n, input logic [2:0] id);
        for (int i = 0; i < n; i++) st(8'h00, 0, 0, 8'h00, 0, 0, id, 0, 8'h00, 8'h00);
    endtask

    task automatic cmp(input string nm, input int idx, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s vec %0d: got 0x%0h, expected 0x%0h", nm, idx, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            e = sb.pop_front();
            $display("vec %0d: ext=%0b id=%0d vld=%0b pend=%02h ovr=%02h",
                     e.idx, ext_intr_sync, irq_id, irq_id_vld, irq_pending, irq_overrun);
            cmp("ext_intr_sync", e.idx, {7'd0, ext_intr_sync}, {7'd0, e.ext});
            cmp("irq_id",        e.idx, {5'd0, irq_id},        {5'd0, e.id});
            cmp("irq_id_vld",    e.idx, {7'd0, irq_id_vld},    {7'd0, e.vld});
            cmp("irq_pending",   e.idx, irq_pending,           e.pend);
            cmp("irq_overrun",   e.idx, irq_overrun,           e.ovr);
        end
    end

    initial begin
        reset = 1'b1; irq_async = '0; irq_edge_mode = '0; irq_mask = '0;
        intr_taken = 1'b0; ertn_w = 1'b0; overrun_clr = '0;
        cur_em = 8'hFF; cur_mask = 8'h00;

        // reset state
        st(8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00);
        st(8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00);

        // edge line 3: request 4 cycles after the rise, service, return
        st(8'h08, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
        st(8'h08, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
        st(8'h08, 0, 0, 8'h00, 0, 0, 0, 0, 8'h08, 8'h00);
        st(8'h00, 0, 0, 8'h00, 0, 1, 3, 0, 8'h08, 8'h00);
        st(8'h00, 1, 0, 8'h00, 0, 1, 3, 1, 8'h00, 8'h00);
        st(8'h00, 1, 0, 8'h00, 0, 1, 3, 1, 8'h00, 8'h00);
        st(8'h00, 0, 1, 8'h00, 0, 0, 3, 0, 8'h00, 8'h00);
        st(8'h00, 1, 0, 8'h00, 0, 0, 3, 0, 8'h00, 8'h00);
        st(8'h00, 0, 0, 8'h00, 0, 0, 3, 0, 8'h00, 8'h00);

        // lines 5 and 2 together: 2 first, then 5 after one low cycle
        st(8'h24, 0, 0, 8'h00, 0, 0, 3, 0, 8'h00, 8'h00);
        st(8'h24, 0, 0, 8'h00, 0, 0, 3, 0, 8'h00, 8'h00);
        st(8'h24, 0, 0, 8'h00, 0, 0, 3, 0, 8'h24, 8'h00);
        st(8'h00, 0, 0, 8'h00, 0, 1, 2, 0, 8'h24, 8'h00);
        st(8'h00, 1, 0, 8'h00, 0, 1, 2, 1, 8'h20, 8'h00);
        st(8'h00, 0, 1, 8'h00, 0, 0, 2, 0, 8'h20, 8'h00);
        st(8'h00, 0, 0, 8'h00, 0, 1, 5, 0, 8'h20, 8'h00);
        st(8'h00, 1, 0, 8'h00, 0, 1, 5, 1, 8'h00, 8'h00);
        st(8'h00, 0, 1, 8'h00, 0, 0, 5, 0, 8'h00, 8'h00);
        st(8'h00, 0, 0, 8'h00, 0, 0, 5, 0, 8'h00, 8'h00);

        // line 6 in REQ preempted by line 1; stray ertn in REQ ignored
        st(8'h40, 0, 0, 8'h00, 0, 0, 5, 0, 8'h00, 8'h00);
        st(8'h40, 0, 0, 8'h00, 0, 0, 5, 0, 8'h00, 8'h00);
        st(8'h40, 0, 0, 8'h00, 0, 0, 5, 0, 8'h40, 8'h00);
        st(8'h42, 0, 0, 8'h00, 0, 1, 6, 0, 8'h40, 8'h00);
        st(8'h42, 0, 1, 8'h00, 0, 1, 6, 0, 8'h40, 8'h00);
        st(8'h42, 0, 0, 8'h00, 0, 1, 6, 0, 8'h42, 8'h00);
        st(8'h42, 0, 0, 8'h00, 0, 1, 1, 0, 8'h42, 8'h00);
        st(8'h42, 1, 0, 8'h00, 0, 1, 1, 1, 8'h40, 8'h00);
        st(8'h42, 0, 1, 8'h00, 0, 0, 1, 0, 8'h40, 8'h00);
        st(8'h42, 0, 0, 8'h00, 0, 1, 6, 0, 8'h40, 8'h00);
        st(8'h42, 1, 0, 8'h00, 0, 1, 6, 1, 8'h00, 8'h00);
        st(8'h00, 0, 1, 8'h00, 0, 0, 6, 0, 8'h00, 8'h00);
        quiet(3, 6);

        // level line 4: re-request after ertn, then withdrawn by masking
        cur_em = 8'hEF;
        st(8'h10, 0, 0, 8'h00, 0, 0, 6, 0, 8'h00, 8'h00);
        st(8'h10, 0, 0, 8'h00, 0, 0, 6, 0, 8'h00, 8'h00);
        st(8'h10, 0, 0, 8'h00, 0, 0, 6, 0, 8'h10, 8'h00);
        st(8'h10, 0, 0, 8'h00, 0, 1, 4, 0, 8'h10, 8'h00);
        st(8'h10, 1, 0, 8'h00, 0, 1, 4, 1, 8'h10, 8'h00);
        st(8'h10, 0, 1, 8'h00, 0, 0, 4, 0, 8'h10, 8'h00);
        st(8'h10, 0, 0, 8'h00, 0, 1, 4, 0, 8'h10, 8'h00);
        cur_mask = 8'h10;
        st(8'h10, 0, 0, 8'h00, 0, 0, 4, 0, 8'h10, 8'h00);
        st(8'h10, 0, 0, 8'h00, 0, 0, 4, 0, 8'h10, 8'h00);
        st(8'h00, 0, 0, 8'h00, 0, 0, 4, 0, 8'h10, 8'h00);
        cur_mask = 8'h00;
        st(8'h00, 0, 0, 8'h00, 0, 1, 4, 0, 8'h10, 8'h00);
        st(8'h00, 1, 0, 8'h00, 0, 1, 4, 1, 8'h00, 8'h00);
        st(8'h00, 0, 1, 8'h00, 0, 0, 4, 0, 8'h00, 8'h00);
        quiet(3, 4);

        // edge line 0 overrun: sticky, cleared by W1C, set wins over clear
        cur_em = 8'hFF;
        st(8'h01, 0, 0, 8'h00, 0, 0, 4, 0, 8'h00, 8'h00);
        st(8'h01, 0, 0, 8'h00, 0, 0, 4, 0, 8'h00, 8'h00);
        st(8'h00, 0, 0, 8'h00, 0, 0, 4, 0, 8'h01, 8'h00);
        st(8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 8'h01, 8'h00);
        st(8'h01, 0, 0, 8'h00, 0, 1, 0, 0, 8'h01, 8'h00);
        st(8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 8'h01, 8'h00);
        st(8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 8'h01, 8'h01);
        st(8'h00, 1, 0, 8'h00, 0, 1, 0, 1, 8'h00, 8'h01);
        st(8'h00, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 8'h01);
        st(8'h00, 0, 0, 8'h01, 0, 0, 0, 0, 8'h00, 8'h00);
        st(8'h01, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
        st(8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
        st(8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h01, 8'h00);
        st(8'h01, 0, 0, 8'h00, 0, 1, 0, 0, 8'h01, 8'h00);
        st(8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 8'h01, 8'h00);
        st(8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 8'h01, 8'h01);
        st(8'h01, 0, 0, 8'h00, 0, 1, 0, 0, 8'h01, 8'h01);
        st(8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 8'h01, 8'h01);
        st(8'h00, 0, 0, 8'h01, 0, 1, 0, 0, 8'h01, 8'h01);
        st(8'h00, 0, 0, 8'h01, 0, 1, 0, 0, 8'h01, 8'h00);
        st(8'h00, 1, 0, 8'h00, 0, 1, 0, 1, 8'h00, 8'h00);
        st(8'h00, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
        quiet(3, 0);

        // reset during SERVICE, then quiet, then a fresh request on line 1
        st(8'h80, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
        st(8'h80, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
        st(8'h80, 0, 0, 8'h00, 0, 0, 0, 0, 8'h80, 8'h00);
        st(8'h00, 0, 0, 8'h00, 0, 1, 7, 0, 8'h80, 8'h00);
        st(8'h00, 1, 0, 8'h00, 0, 1, 7, 1, 8'h00, 8'h00);
        st(8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00);
        quiet(4, 0);
        st(8'h02, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
        st(8'h02, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
        st(8'h02, 0, 0, 8'h00, 0, 0, 0, 0, 8'h02, 8'h00);
        st(8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 8'h02, 8'h00);
        st(8'h00, 1, 0, 8'h00, 0, 1, 1, 1, 8'h00, 8'h00);
        st(8'h00, 0, 1, 8'h00, 0, 0, 1, 0, 8'h00, 8'h00);

        @(posedge clk);
        #1;
        for (int k = 0; k < vecs.size(); k++) begin
            exp_t x;
            reset         = vecs[k].rst;
            irq_async     = vecs[k].irq;
            irq_edge_mode = vecs[k].emode;
            irq_mask      = vecs[k].mask;
            intr_taken    = vecs[k].tk;
            ertn_w        = vecs[k].er;
            overrun_clr   = vecs[k].oclr;
            x.cyc = cyc_cnt + 1; x.idx = k;
            x.ext = vecs[k].ext; x.id = vecs[k].id; x.vld = vecs[k].vld;
            x.pend = vecs[k].pend; x.ovr = vecs[k].ovr;
            sb.push_back(x);
            @(posedge clk);
            #1;
        end
        reset = 1'b0; irq_async = '0; intr_taken = 1'b0; ertn_w = 1'b0; overrun_clr = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
